// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack controller and the SP register it drives.
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_CLR  = 2'b01;
  localparam logic [1:0] SP_INC  = 2'b10;
  localparam logic [1:0] SP_DEC  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEC,
    ST_WR,
    ST_RD,
    ST_INC,
    ST_CLR
  } state_e;

  function automatic logic is_push(input op_e o);
    return (o == OP_PUSH) || (o == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Full-descending stack sequencer: steps the external SP register and the
// stack RAM through PUSH/POP/CALL/RET with bound checks before every SP move.
//
// state | meaning
// IDLE  | ready; accepts sp_clear or an op, emits result pulses
// DEC   | pre-decrement SP for a push-type op
// WR    | write captured data at the decremented SP
// RD    | read RAM at current SP for a pop-type op
// INC   | post-increment SP, capture read data
// CLR   | return SP to the empty value
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int N        = 8,
  parameter int SP_TOP   = 128,
  parameter int SP_LIMIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sp_clear,
  input  logic         op_valid,
  input  logic [1:0]   op,
  input  logic [N-1:0] op_wdata,
  output logic         op_ready,
  output logic         done,
  output logic [N-1:0] pop_data,
  output logic         pc_load,
  output logic [N-1:0] pc_val,
  output logic         err_overflow,
  output logic         err_underflow,
  output logic [1:0]   sp_ctrl,
  input  logic [N-1:0] sp_in,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  output logic         mem_re,
  input  logic [N-1:0] mem_rdata
);

  localparam logic [N-1:0] LP_TOP   = N'(SP_TOP);
  localparam logic [N-1:0] LP_LIMIT = N'(SP_LIMIT);

  state_e       r_state;
  state_e       w_state_nxt;
  op_e          r_op;
  logic [N-1:0] r_data;
  logic [N-1:0] r_pop_data;
  logic [N-1:0] r_pc_val;
  logic         r_done;
  logic         r_ovf;
  logic         r_udf;
  logic         r_pcl;
  logic         w_done_nxt;
  logic         w_ovf_nxt;
  logic         w_udf_nxt;
  logic         w_pcl_nxt;
  logic         w_we;
  logic         w_re;
  logic [1:0]   w_sp_ctrl;
  logic         w_accept;

  // sp_clear wins over a pending op, so the op is not handshaken that cycle
  assign w_accept = (r_state == ST_IDLE) && !sp_clear && op_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_PUSH;
      r_data     <= '0;
      r_pop_data <= '0;
      r_pc_val   <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_pcl      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      r_udf   <= w_udf_nxt;
      r_pcl   <= w_pcl_nxt;
      if (w_accept) begin
        r_op   <= op_e'(op);
        r_data <= op_wdata;
      end
      if (r_state == ST_INC) begin
        if (r_op == OP_RET) r_pc_val   <= mem_rdata;
        else                r_pop_data <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sp_ctrl   = SP_HOLD;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_udf_nxt   = 1'b0;
    w_pcl_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sp_clear) begin
          w_state_nxt = ST_CLR;
        end else if (op_valid) begin
          if (is_push(op_e'(op))) begin
            if (sp_in == LP_LIMIT) begin
              w_done_nxt = 1'b1;
              w_ovf_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_DEC;
            end
          end else if (sp_in == LP_TOP) begin
            w_done_nxt = 1'b1;
            w_udf_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_DEC: begin
        w_sp_ctrl   = SP_DEC;
        w_state_nxt = ST_WR;
      end
      ST_WR: begin
        w_we        = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RD: begin
        w_re        = 1'b1;
        w_state_nxt = ST_INC;
      end
      ST_INC: begin
        w_sp_ctrl   = SP_INC;
        w_done_nxt  = 1'b1;
        w_pcl_nxt   = (r_op == OP_RET);
        w_state_nxt = ST_IDLE;
      end
      ST_CLR: begin
        w_sp_ctrl   = SP_CLR;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // rst overrides combinationally so an op in flight cannot write or pulse
  assign op_ready      = (r_state == ST_IDLE) && !sp_clear && !rst;
  assign sp_ctrl       = rst ? SP_CLR : w_sp_ctrl;
  assign mem_we        = w_we && !rst;
  assign mem_re        = w_re && !rst;
  assign mem_addr      = sp_in;
  assign mem_wdata     = r_data;
  assign done          = r_done && !rst;
  assign err_overflow  = r_ovf && !rst;
  assign err_underflow = r_udf && !rst;
  assign pc_load       = r_pcl && !rst;
  assign pop_data      = r_pop_data;
  assign pc_val        = r_pc_val;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: two instances (default limit and SP_LIMIT=126)
// with SP register and RAM models, checked against a LIFO queue model.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sp_clear [2];
  logic       op_valid [2];
  logic [1:0] op       [2];
  logic [7:0] op_wdata [2];
  logic       op_ready [2];
  logic       done     [2];
  logic [7:0] pop_data [2];
  logic       pc_load  [2];
  logic [7:0] pc_val   [2];
  logic       err_ovf  [2];
  logic       err_udf  [2];
  logic [1:0] sp_ctrl  [2];
  logic [7:0] sp_in    [2];
  logic [7:0] mem_addr [2];
  logic [7:0] mem_wdata[2];
  logic       mem_we   [2];
  logic       mem_re   [2];
  logic [7:0] mem_rdata[2];
  logic [7:0] ram      [2][256];

  logic [7:0] stk[2][$];
  int         lim[2] = '{1, 126};
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.N(8), .SP_TOP(128), .SP_LIMIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .sp_clear(sp_clear[0]), .op_valid(op_valid[0]),
    .op(op[0]), .op_wdata(op_wdata[0]), .op_ready(op_ready[0]), .done(done[0]),
    .pop_data(pop_data[0]), .pc_load(pc_load[0]), .pc_val(pc_val[0]),
    .err_overflow(err_ovf[0]), .err_underflow(err_udf[0]), .sp_ctrl(sp_ctrl[0]),
    .sp_in(sp_in[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0])
  );

  stack_ctrl #(.N(8), .SP_TOP(128), .SP_LIMIT(126)) u_dut1 (
    .clk(clk), .rst(rst), .sp_clear(sp_clear[1]), .op_valid(op_valid[1]),
    .op(op[1]), .op_wdata(op_wdata[1]), .op_ready(op_ready[1]), .done(done[1]),
    .pop_data(pop_data[1]), .pc_load(pc_load[1]), .pc_val(pc_val[1]),
    .err_overflow(err_ovf[1]), .err_underflow(err_udf[1]), .sp_ctrl(sp_ctrl[1]),
    .sp_in(sp_in[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1])
  );

  // SP register updates on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      case (sp_ctrl[k])
        2'b01:   sp_in[k] <= 8'd128;
        2'b10:   sp_in[k] <= sp_in[k] + 8'd1;
        2'b11:   sp_in[k] <= sp_in[k] - 8'd1;
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
      if (mem_re[k]) mem_rdata[k] <= ram[k][mem_addr[k]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_sp(input int k);
    return 8'(128 - stk[k].size());
  endfunction

  // Issue one op, follow it to its done pulse and compare against the queue model.
  task automatic do_op(input int k, input logic [1:0] o, input logic [7:0] d);
    bit         push, err, acc, got;
    logic [7:0] exp_val, exp_addr, wa, wd, ra, pd0, pc0;
    int         n, nwe, nre;
    push    = (o == 2'b00) || (o == 2'b10);
    exp_val = 8'h00;
    if (push) begin
      err = (128 - stk[k].size()) == lim[k];
      if (!err) stk[k].push_back(d);
      exp_addr = exp_sp(k);
    end else begin
      err = (stk[k].size() == 0);
      if (!err) exp_val = stk[k].pop_back();
      exp_addr = exp_sp(k) - 8'd1;
    end
    op_valid[k] = 1'b1; op[k] = o; op_wdata[k] = d;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = op_ready[k];
      @(posedge clk); #1;
    end
    op_valid[k] = 1'b0; op[k] = 2'($urandom); op_wdata[k] = 8'($urandom);
    chk("accept", 32'(acc), 1);
    if (!acc) return;
    pd0 = pop_data[k]; pc0 = pc_val[k];
    nwe = 0; nre = 0; wa = 0; wd = 0; ra = 0; got = 1'b0; n = 1;
    while (n <= 8) begin
      if (mem_we[k]) begin nwe++; wa = mem_addr[k]; wd = mem_wdata[k]; end
      if (mem_re[k]) begin nre++; ra = mem_addr[k]; end
      if (done[k]) begin got = 1'b1; break; end
      @(posedge clk); #1; n++;
    end
    chk("done_seen", 32'(got), 1);
    chk("latency", 32'(n), err ? 1 : 3);
    chk("err_overflow", 32'(err_ovf[k]), 32'(push && err));
    chk("err_underflow", 32'(err_udf[k]), 32'(!push && err));
    chk("write_count", 32'(nwe), 32'(push && !err));
    chk("read_count", 32'(nre), 32'(!push && !err));
    if (push && !err) begin
      chk("write_addr", 32'(wa), 32'(exp_addr));
      chk("write_data", 32'(wd), 32'(d));
    end
    if (!push && !err) chk("read_addr", 32'(ra), 32'(exp_addr));
    chk("pc_load", 32'(pc_load[k]), 32'(o == 2'b11 && !err));
    chk("pop_data", 32'(pop_data[k]), 32'((o == 2'b01 && !err) ? exp_val : pd0));
    chk("pc_val", 32'(pc_val[k]), 32'((o == 2'b11 && !err) ? exp_val : pc0));
    chk("sp_after", 32'(sp_in[k]), 32'(exp_sp(k)));
    chk("done_quiet", {29'd0, mem_we[k], sp_ctrl[k] != 2'b00, mem_re[k]}, 0);
    @(posedge clk); #1;
    chk("pulse_end", {28'd0, done[k], pc_load[k], err_ovf[k], err_udf[k]}, 0);
  endtask

  task automatic do_clear(input int k);
    sp_clear[k] = 1'b1;
    @(posedge clk); #1;
    sp_clear[k] = 1'b0;
    chk("clr_ready", 32'(op_ready[k]), 0);
    chk("clr_ctrl", 32'(sp_ctrl[k]), 32'h1);
    chk("clr_done", 32'(done[k]), 0);
    @(posedge clk); #1;
    stk[k].delete();
    chk("clr_sp", 32'(sp_in[k]), 128);
    chk("clr_ready2", 32'(op_ready[k]), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t_acc[$];
    int         v;
    logic [7:0] saved;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sp_clear[k] = 1'b0; op_valid[k] = 1'b0; op[k] = 2'b00; op_wdata[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp_ctrl", 32'(sp_ctrl[0]), 32'h1);
    chk("rst_pulses", {28'd0, done[0], mem_we[0], mem_re[0], err_ovf[0]}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_sp", 32'(sp_in[k]), 128);
      chk("rst_ready", 32'(op_ready[k]), 1);
      chk("rst_pop_data", 32'(pop_data[k]), 0);
      chk("rst_pc_val", 32'(pc_val[k]), 0);
    end

    do_op(0, 2'b00, 8'h5A);
    do_op(0, 2'b01, 8'h00);
    do_op(0, 2'b01, 8'h00);
    do_op(0, 2'b10, 8'h34);
    do_op(0, 2'b11, 8'h00);

    do_op(1, 2'b00, 8'h11);
    do_op(1, 2'b10, 8'h22);
    do_op(1, 2'b00, 8'h33);
    do_op(1, 2'b11, 8'h00);
    do_op(1, 2'b01, 8'h00);

    // back-to-back pushes with op_valid held
    do_clear(0);
    op_valid[0] = 1'b1; op[0] = 2'b00; v = 1; op_wdata[0] = 8'(v);
    for (int c = 0; c < 20 && v <= 3; c++) begin
      bit r;
      r = op_ready[0];
      @(posedge clk); #1;
      if (r) begin
        t_acc.push_back(c); stk[0].push_back(8'(v)); v++; op_wdata[0] = 8'(v);
      end
    end
    op_valid[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_count", 32'(t_acc.size()), 3);
    if (t_acc.size() == 3) begin
      chk("b2b_gap1", 32'(t_acc[1] - t_acc[0]), 3);
      chk("b2b_gap2", 32'(t_acc[2] - t_acc[1]), 3);
    end
    chk("b2b_sp", 32'(sp_in[0]), 32'(exp_sp(0)));
    do_op(0, 2'b01, 8'h00);
    do_op(0, 2'b01, 8'h00);
    do_clear(0);
    do_op(0, 2'b01, 8'h00);

    // randomized traffic on both instances
    for (int i = 0; i < 120; i++) begin
      int k;
      k = (i % 3 == 2) ? 1 : 0;
      if ($urandom_range(0, 19) == 0) do_clear(k);
      else do_op(k, 2'($urandom_range(0, 3)), 8'($urandom));
    end

    // reset while in WR: no write, no done, SP back to empty
    do_clear(0);
    saved = ram[0][127];
    op_valid[0] = 1'b1; op[0] = 2'b00; op_wdata[0] = saved ^ 8'hFF;
    chk("wr_rst_ready", 32'(op_ready[0]), 1);
    @(posedge clk); #1;
    op_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("wr_rst_we_pre", 32'(mem_we[0]), 1);
    rst = 1'b1;
    #0;
    chk("wr_rst_we", 32'(mem_we[0]), 0);
    chk("wr_rst_ctrl", 32'(sp_ctrl[0]), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("wr_rst_nodone", 32'(done[0]), 0);
      @(posedge clk); #1;
    end
    stk[0].delete(); stk[1].delete();
    chk("wr_rst_ram", 32'(ram[0][127]), 32'(saved));
    chk("wr_rst_sp", 32'(sp_in[0]), 128);
    do_op(0, 2'b01, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the stack-pointer register and the stack RAM.
- Accepts PUSH/POP/CALL/RET requests from the instruction decoder and drives the SP register's 2-bit ctrl (00 hold, 01 clear to top, 10 +1, 11 −1).
- Drives the stack RAM address/enables and reports results.
- Stack is full-descending: the empty SP equals SP_TOP; push pre-decrements, pop post-increments.

Parameters:
- N, 8, data/address width (matches SP register width).
- SP_TOP, 128, SP value when the stack is empty (SP register clear value).
- SP_LIMIT, 1, lowest legal SP after a push; a push with sp_in == SP_LIMIT overflows.

Ports:
- clk  in  1  system clock; controller logic on rising edge (SP register updates on falling edge).
- rst  in  1  synchronous, active-high reset.
- sp_clear  in  1  request to reset the stack to empty.
- op_valid  in  1  request strobe.
- op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- op_wdata  in  N  push data (PUSH) or return address (CALL).
- op_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when an op completes or is rejected.
- pop_data  out  N  popped value; valid with done after POP.
- pc_load  out  1  one-cycle pulse with done after RET; pc_val is valid.
- pc_val  out  N  popped return address.
- err_overflow  out  1  one-cycle pulse with done; push-type op rejected.
- err_underflow  out  1  one-cycle pulse with done; pop-type op rejected.
- sp_ctrl  out  2  to SP register ctrl.
- sp_in  in  N  SP register output.
- mem_addr  out  N  stack RAM address; equals sp_in whenever mem_we or mem_re is high.
- mem_wdata  out  N  stack RAM write data.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable; synchronous read, data on mem_rdata in the next cycle.
- mem_rdata  in  N  RAM read data.

Behaviour:
- States: IDLE, DEC, WR, RD, INC, CLR.
- Handshake: an op is accepted on the rising edge where op_valid && op_ready. op and op_wdata are captured into internal registers at accept.
- Reset:
  - While rst is high: state = IDLE, sp_ctrl = 01 (clears the SP register on that falling edge), and all pulses, mem_we and mem_re are 0.
  - pop_data and pc_val reset to 0.
  - rst mid-operation aborts the op with no done pulse.
- sp_clear (checked in IDLE only, priority over op_valid):
  - Enter CLR; sp_ctrl = 01 for one cycle, then IDLE.
  - No done pulse; op_ready is low during CLR.
- PUSH/CALL:
  - If sp_in == SP_LIMIT at accept: no state change, SP untouched, done and err_overflow pulse next cycle.
  - Otherwise: DEC (sp_ctrl = 11), then WR (mem_we = 1, mem_addr = sp_in, which is already decremented; mem_wdata = captured data), then IDLE with done pulse.
  - Latency: done 3 cycles after accept.
- POP/RET:
  - If sp_in == SP_TOP at accept: done and err_underflow pulse next cycle.
  - Otherwise: RD (mem_re = 1, mem_addr = sp_in), then INC (sp_ctrl = 10, mem_rdata captured at end of cycle), then IDLE.
  - In IDLE: done pulses; pop_data (POP) or pc_val with pc_load (RET) is updated.
  - Latency: 3 cycles.
- In all states except DEC, INC and CLR (and reset), sp_ctrl = 00.
- A new op may be accepted in the same IDLE cycle that done pulses, so the throughput is one op per 3 cycles.
- op_valid while busy is ignored; the requester holds it until it is accepted.
- err pulses never coincide with mem_we, mem_re or a non-hold sp_ctrl.
- sp_in is only ever compared, never modified internally; no wrap-around can occur because the bounds are checked before every decrement or increment.

Decomposition:
- Shared package holds:
  - op encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET);
  - SP ctrl encodings (SP_HOLD, SP_CLR, SP_INC, SP_DEC), also used by the SP register;
  - the state enumeration.
- Single module; no sub-module needed. The SP register is instantiated alongside at the next level up.

Test Plan:
- Reset: hold rst 2 cycles → sp_ctrl = 01, SP = 128, op_ready = 1, no pulses.
- PUSH 0x5A from SP = 128 → DEC then WR writes 0x5A to addr 127; done at +3; SP = 127.
- Then POP → read addr 127; done at +3 with pop_data = 0x5A; SP = 128. Then POP again → err_underflow + done at +1; SP stays 128; no mem_re.
- CALL 0x34 then RET → pc_load pulse with pc_val = 0x34; SP back to 128.
- With SP_LIMIT = 126: PUSH, PUSH (SP = 126), third PUSH → err_overflow, no mem_we, SP = 126.
- Back-to-back PUSH 1, 2, 3 with op_valid held high → accepts every 3 cycles. Then sp_clear → SP = 128 after CLR, next POP underflows. Then assert rst during WR → no write, no done, SP = 128.
